pll_lock_reset_sequencer: RTL
=============================

Name: pll_lock_reset_sequencer

Overview:
- Parametrised successor to the fixed ULX3S PLL wrapper; runs in the PLL output clock domain.
- Qualifies the raw PLL lock signal and releases per-domain resets in a staggered order.
- Generates NUM_CH programmable clock-enable strobes, so one PLL clock serves several slower logic rates.
- Detects loss of lock, re-asserts every reset, re-sequences on relock and counts lock-loss events.

Parameters:
NUM_CH, 3, number of reset/clock-enable channels (1..8)
DIV_W, 8, width of each channel divider ratio
LOCK_STABLE, 16, consecutive synchronised-lock cycles required before the first release (>=1)
STAGGER, 4, cycles between successive channel releases (>=1)

Ports:
clock  in  1  PLL output clock; all logic on rising edge
reset  in  1  synchronous, active-high
pll_locked  in  1  raw PLL LOCK, asynchronous to clock
div_ratio  in  NUM_CH*DIV_W  channel i in bits [i*DIV_W +: DIV_W]; strobe period = value+1
rst_out  out  NUM_CH  per-channel synchronous reset, active-high
ce  out  NUM_CH  per-channel one-cycle clock-enable strobe
ready  out  1  all channels released and running
lock_loss_count  out  8  saturating count of lock losses after first release

Behaviour:
- Reset (synchronous, active-high; reset has priority over all other logic, including mid-sequence):
  - rst_out = all 1, ce = 0, ready = 0, lock_loss_count = 0.
  - State = WAIT_LOCK; synchroniser flops = 0; all counters = 0.
- Synchroniser: 2-flop on pll_locked; lk = second flop output. No other logic samples pll_locked.
- FSM:
  - WAIT_LOCK: stable counter = 0. lk=1 -> STABLE.
  - STABLE: increment stable counter each cycle with lk=1. lk=0 -> WAIT_LOCK, lock_loss_count NOT incremented. Counter reaching LOCK_STABLE -> deassert rst_out[0], go to RELEASE with channel index 1 and stagger counter 0.
  - RELEASE: every STAGGER cycles deassert rst_out[index], index++. After rst_out[NUM_CH-1] falls -> RUN. NUM_CH=1: STABLE goes straight to RUN.
  - RUN: ready = 1, registered, rising one cycle after the last rst_out falls.
  - Lock loss: lk=0 in RELEASE or RUN -> on that edge rst_out = all 1, ce = 0, ready = 0, state = WAIT_LOCK, lock_loss_count += 1, saturating at 255.
- Timing: lk first high at edge T -> rst_out[0] low at edge T+LOCK_STABLE; rst_out[i] low at T+LOCK_STABLE+i*STAGGER. pll_locked sampled high at edge E gives T = E+2.
- Clock enables, per channel i:
  - While rst_out[i]=1: divider counter = 0, ce[i] = 0.
  - The channel divider value is latched on the edge rst_out[i] falls; later div_ratio changes are ignored until the next release.
  - After release: counter increments each cycle; when counter == latched div it wraps to 0 and ce[i] (registered) pulses on the following cycle.
  - First ce[i] pulse is div+1 cycles after the release edge; pulse period is div+1.
  - div=0: ce[i] is high continuously, starting the cycle after release.
- Lock lost on the same edge a release would occur: loss wins and the channel stays in reset.
- Outputs are glitch-free registers; no combinational path from pll_locked to any output.

Test Plan:
1. NUM_CH=3, LOCK_STABLE=4, STAGGER=2; reset then pll_locked=1 sampled at edge E -> rst_out[0] falls at E+6, rst_out[1] at E+8, rst_out[2] at E+10; ready=1 at E+11; lock_loss_count=0.
2. div_ratio ch0=0, ch1=2, ch2=255 after the scenario-1 release -> ce[0] high every cycle from E+7; ce[1] pulses at E+11, E+14, E+17; ce[2] pulses at E+266, then every 256 cycles.
3. In RUN, drop pll_locked for 1 cycle -> 2 edges later rst_out=111, ce=000, ready=0, lock_loss_count=1; with lock restored, full re-sequence repeats with the timing of scenario 1.
4. pll_locked glitches low for 1 cycle during STABLE (count 2 of 4) -> no release, lock_loss_count stays 0, stable count restarts; release occurs LOCK_STABLE cycles after lk returns high.
5. Assert reset mid-RELEASE, after rst_out[0] is low -> next edge rst_out=111, ce=0, ready=0, count=0; 256 forced lock-loss events -> count saturates at 255.
6. Change div_ratio ch1 from 2 to 5 while in RUN -> period stays 3 until a lock loss and re-release, then becomes 6.

Source files
------------

// File: rtl/pll_lock_reset_sequencer.sv
// PLL lock qualifier with staggered per-channel reset release,
// programmable clock-enable strobes and lock-loss counting.
module pll_lock_reset_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_STABLE = 16,
  parameter int STAGGER     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready,
  output logic [7:0]              lock_loss_count
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(STAGGER + 1);
  localparam int IW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t state;

  logic [1:0]        sync;
  logic              lk;
  logic [SW-1:0]     stable_cnt;
  logic [TW-1:0]     stag_cnt;
  logic [IW-1:0]     idx;
  logic              lk_loss;
  logic [NUM_CH-1:0] rel;

  logic [DIV_W-1:0]  cnt   [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];

  assign lk = sync[1];

  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], pll_locked};
  end

  assign lk_loss = !lk && (state == RELEASE || state == RUN);

  // One-hot channel released on this edge; empty whenever lk is low.
  always_comb begin
    rel = '0;
    if (lk) begin
      unique case (state)
        STABLE:
          if (stable_cnt == SW'(LOCK_STABLE - 1))
            rel = NUM_CH'(1);
        RELEASE:
          if (stag_cnt == TW'(STAGGER - 1))
            rel = NUM_CH'(1) << idx;
        default: rel = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      stable_cnt      <= '0;
      stag_cnt        <= '0;
      idx             <= '0;
      rst_out         <= '1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else if (lk_loss) begin
      state      <= WAIT_LOCK;
      stable_cnt <= '0;
      rst_out    <= '1;
      ready      <= 1'b0;
      if (lock_loss_count != 8'hff)
        lock_loss_count <= lock_loss_count + 8'd1;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          stable_cnt <= '0;
          if (lk) state <= STABLE;
        end
        STABLE: begin
          if (!lk) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
          end else if (rel[0]) begin
            rst_out  <= rst_out & ~rel;
            stag_cnt <= '0;
            idx      <= IW'(1);
            state    <= (NUM_CH == 1) ? RUN : RELEASE;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        RELEASE: begin
          if (|rel) begin
            rst_out  <= rst_out & ~rel;
            stag_cnt <= '0;
            idx      <= idx + IW'(1);
            if (idx == IW'(NUM_CH - 1))
              state <= RUN;
          end else begin
            stag_cnt <= stag_cnt + TW'(1);
          end
        end
        RUN: ready <= 1'b1;
      endcase
    end
  end

  // Divider value is captured on the release edge only.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        cnt[i]   <= '0;
        div_q[i] <= '0;
        ce[i]    <= 1'b0;
      end else if (lk_loss) begin
        cnt[i] <= '0;
        ce[i]  <= 1'b0;
      end else begin
        if (rel[i])
          div_q[i] <= div_ratio[i*DIV_W +: DIV_W];
        if (rst_out[i]) begin
          cnt[i] <= '0;
          ce[i]  <= 1'b0;
        end else if (cnt[i] == div_q[i]) begin
          cnt[i] <= '0;
          ce[i]  <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + DIV_W'(1);
          ce[i]  <= 1'b0;
        end
      end
    end
  end

endmodule
